// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: PC, req/ack instruction-memory port and the IF/ID output slot.
// Define FETCH_SKID_EN to add a one-entry skid buffer behind the slot (1 instr/cycle).
module if_fetch_unit #(
  parameter int unsigned           BIT_NUMBER = 32,
  parameter logic [BIT_NUMBER-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [BIT_NUMBER-1:0] branch_addr,
  output logic                  imem_req,
  output logic [BIT_NUMBER-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [BIT_NUMBER-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [BIT_NUMBER-1:0] pc_out,
  output logic [BIT_NUMBER-1:0] instruction_out
);

  localparam logic [BIT_NUMBER-1:0] PcStep = BIT_NUMBER'(4);

  logic [BIT_NUMBER-1:0] pc_q, pc_d;
  logic                  req_q, req_d;
  logic [BIT_NUMBER-1:0] addr_q, addr_d;
  logic                  discard_q, discard_d;
  logic                  valid_q, valid_d;
  logic [BIT_NUMBER-1:0] slot_pc_q, slot_pc_d;
  logic [BIT_NUMBER-1:0] slot_instr_q, slot_instr_d;
`ifdef FETCH_SKID_EN
  logic                  skid_valid_q, skid_valid_d;
  logic [BIT_NUMBER-1:0] skid_pc_q, skid_pc_d;
  logic [BIT_NUMBER-1:0] skid_instr_q, skid_instr_d;
`endif

  logic                  ack_ok;
  logic                  consume;
  logic                  req_open;
  logic                  occ_full;
  logic [BIT_NUMBER-1:0] ack_pc;

  always_comb begin
    pc_d         = pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    discard_d    = discard_q;
    valid_d      = valid_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
`ifdef FETCH_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
`endif
    occ_full = 1'b0;
    ack_ok   = req_q && imem_ack && !discard_q;
    consume  = valid_q && !freeze;
    req_open = req_q && !imem_ack;
    ack_pc   = addr_q + PcStep;

    // Any ack closes the open request; a discarded one also ends the discard window.
    if (req_q && imem_ack) begin
      req_d     = 1'b0;
      discard_d = 1'b0;
    end

    if (branch_taken) begin
      valid_d = 1'b0;
`ifdef FETCH_SKID_EN
      skid_valid_d = 1'b0;
`endif
      pc_d = branch_addr;
      if (req_open) begin
        discard_d = 1'b1;
      end else begin
        req_d  = 1'b1;
        addr_d = branch_addr;
        pc_d   = branch_addr + PcStep;
      end
    end else begin
`ifdef FETCH_SKID_EN
      if (consume) begin
        if (skid_valid_q) begin
          slot_pc_d    = skid_pc_q;
          slot_instr_d = skid_instr_q;
          skid_valid_d = ack_ok;
          if (ack_ok) begin
            skid_pc_d    = ack_pc;
            skid_instr_d = imem_rdata;
          end
        end else if (ack_ok) begin
          slot_pc_d    = ack_pc;
          slot_instr_d = imem_rdata;
        end else begin
          valid_d = 1'b0;
        end
      end else if (ack_ok) begin
        if (valid_q) begin
          skid_valid_d = 1'b1;
          skid_pc_d    = ack_pc;
          skid_instr_d = imem_rdata;
        end else begin
          valid_d      = 1'b1;
          slot_pc_d    = ack_pc;
          slot_instr_d = imem_rdata;
        end
      end
      // Skid only fills behind a full slot, so an empty skid means occupancy <= 1.
      occ_full = skid_valid_d;
`else
      if (ack_ok) begin
        valid_d      = 1'b1;
        slot_pc_d    = ack_pc;
        slot_instr_d = imem_rdata;
      end else if (consume) begin
        valid_d = 1'b0;
      end
      occ_full = valid_d;
`endif
      if (!req_open && !occ_full) begin
        req_d  = 1'b1;
        addr_d = pc_q;
        pc_d   = pc_q + PcStep;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= '0;
      discard_q    <= 1'b0;
      valid_q      <= 1'b0;
      slot_pc_q    <= '0;
      slot_instr_q <= '0;
`ifdef FETCH_SKID_EN
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
`endif
    end else begin
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      discard_q    <= discard_d;
      valid_q      <= valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
`ifdef FETCH_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
`endif
    end
  end

  assign imem_req        = req_q;
  assign imem_addr       = addr_q;
  assign if_valid        = valid_q;
  assign pc_out          = valid_q ? slot_pc_q : '0;
  assign instruction_out = valid_q ? slot_instr_q : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model with programmable ack delay and a
// scoreboard of expected {pc_out, instruction_out} pairs popped as words are consumed.
module tb_if_fetch_unit;

`ifdef FETCH_SKID_EN
  localparam bit SKID = 1'b1;
  localparam int CADENCE = 1;
`else
  localparam bit SKID = 1'b0;
  localparam int CADENCE = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] sb_q[$];
  logic [31:0] ack_delay = '0;
  logic [31:0] wait_cnt;

  if_fetch_unit #(.BIT_NUMBER(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .pc_out          (pc_out),
    .instruction_out (instruction_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0193) ^ 32'hC0DE_0000;
  endfunction

  // Memory: acks after ack_delay cycles of an open request (0 = same cycle).
  assign imem_ack   = imem_req && (wait_cnt == ack_delay);
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= '0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 32'd1;
    else wait_cnt <= '0;
  end

  function automatic logic [63:0] exp_pair(input logic [31:0] a);
    return {a + 32'd4, mem_word(a)};
  endfunction

  task automatic do_reset(input logic [31:0] dly);
    rst_n = 1'b0;
    freeze = 1'b1;
    branch_taken = 1'b0;
    branch_addr = '0;
    ack_delay = dly;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({imem_req, imem_addr, if_valid, pc_out, instruction_out} !== '0) begin
      fails++;
      $display("FAIL reset_async: got req=%b addr=%h v=%b pc=%h ins=%h expected all 0",
               imem_req, imem_addr, if_valid, pc_out, instruction_out);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({imem_req, imem_addr, if_valid, pc_out, instruction_out} !== '0) begin
      fails++;
      $display("FAIL reset_held: got req=%b addr=%h v=%b expected all 0",
               imem_req, imem_addr, if_valid);
    end
    do_reset(0);
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    int last = 0;
    int pops = 0;
    logic [63:0] e;
    do_reset(0);
    for (int i = 0; i < 3; i++) sb_q.push_back(exp_pair(32'(4 * i)));
    for (int c = 0; c < 100 && sb_q.size() > 0; c++) begin
      @(negedge clk);
      freeze = 1'b1;
      if (if_valid) begin
        e = sb_q.pop_front();
        freeze = 1'b0;
        tests++;
        if ({pc_out, instruction_out} !== e) begin
          fails++;
          $display("FAIL zero_wait_word: got %h expected %h", {pc_out, instruction_out}, e);
        end
        if (pops > 0) begin
          tests++;
          if (c - last != CADENCE) begin
            fails++;
            $display("FAIL zero_wait_cadence: got %0d cycles expected %0d", c - last, CADENCE);
          end
        end
        last = c;
        pops++;
      end
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL zero_wait_timeout: got %0d words left expected 0", sb_q.size());
    end
  endtask

  task automatic test_ack_delay();
    bit pend = 1'b0;
    bit chk = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] chk_pc = '0;
    logic [63:0] e;
    do_reset(3);
    for (int i = 0; i < 3; i++) sb_q.push_back(exp_pair(32'(4 * i)));
    for (int c = 0; c < 200 && sb_q.size() > 0; c++) begin
      @(negedge clk);
      freeze = 1'b1;
      if (pend) begin
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin
          fails++;
          $display("FAIL delay_hold: got req=%b addr=%h expected req=1 addr=%h",
                   imem_req, imem_addr, pend_addr);
        end
      end
      if (chk) begin
        tests++;
        if (if_valid !== 1'b1 || pc_out !== chk_pc) begin
          fails++;
          $display("FAIL delay_valid: got v=%b pc=%h expected v=1 pc=%h", if_valid, pc_out, chk_pc);
        end
        chk = 1'b0;
      end
      if (imem_req && imem_ack) begin
        chk = 1'b1;
        chk_pc = imem_addr + 32'd4;
        pend = 1'b0;
      end else if (imem_req && !pend) begin
        pend = 1'b1;
        pend_addr = imem_addr;
      end
      if (if_valid) begin
        e = sb_q.pop_front();
        freeze = 1'b0;
        tests++;
        if ({pc_out, instruction_out} !== e) begin
          fails++;
          $display("FAIL delay_word: got %h expected %h", {pc_out, instruction_out}, e);
        end
      end
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL delay_timeout: got %0d words left expected 0", sb_q.size());
    end
  endtask

  task automatic test_freeze();
    int pops = 0;
    int held = 0;
    logic [63:0] e;
    do_reset(0);
    for (int i = 0; i < 6; i++) sb_q.push_back(exp_pair(32'(4 * i)));
    for (int c = 0; c < 100 && sb_q.size() > 0; c++) begin
      @(negedge clk);
      freeze = 1'b1;
      if (if_valid && pops == 1 && held < 5) begin
        held++;
        tests++;
        if ({pc_out, instruction_out} !== exp_pair(32'h4)) begin
          fails++;
          $display("FAIL freeze_stable: got %h expected %h", {pc_out, instruction_out},
                   exp_pair(32'h4));
        end
      end else if (if_valid) begin
        e = sb_q.pop_front();
        freeze = 1'b0;
        pops++;
        tests++;
        if ({pc_out, instruction_out} !== e) begin
          fails++;
          $display("FAIL freeze_word: got %h expected %h", {pc_out, instruction_out}, e);
        end
      end
    end
    tests++;
    if (sb_q.size() != 0 || held != 5) begin
      fails++;
      $display("FAIL freeze_drain: got left=%0d held=%0d expected left=0 held=5", sb_q.size(), held);
    end
  endtask

  task automatic test_branch_open();
    bit found = 1'b0;
    logic [63:0] e;
    do_reset(3);
    for (int i = 0; i < 2; i++) sb_q.push_back(exp_pair(32'(4 * i)));
    for (int c = 0; c < 100 && sb_q.size() > 0; c++) begin
      @(negedge clk);
      freeze = 1'b1;
      if (if_valid) begin
        e = sb_q.pop_front();
        freeze = 1'b0;
        tests++;
        if ({pc_out, instruction_out} !== e) begin
          fails++;
          $display("FAIL branch_pre_word: got %h expected %h", {pc_out, instruction_out}, e);
        end
      end
    end
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      freeze = 1'b1;
      if (imem_req && !imem_ack && imem_addr == 32'h8) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL branch_open_req: got no open request expected request to 00000008");
    end else begin
      branch_taken = 1'b1;
      branch_addr = 32'h100;
      @(negedge clk);
      branch_taken = 1'b0;
      tests++;
      if (if_valid !== 1'b0) begin
        fails++;
        $display("FAIL branch_flush: got if_valid=%b expected 0", if_valid);
      end
      for (int i = 0; i < 3; i++) sb_q.push_back(exp_pair(32'h100 + 32'(4 * i)));
      for (int c = 0; c < 100 && sb_q.size() > 0; c++) begin
        @(negedge clk);
        freeze = 1'b1;
        if (if_valid) begin
          e = sb_q.pop_front();
          freeze = 1'b0;
          tests++;
          if ({pc_out, instruction_out} !== e) begin
            fails++;
            $display("FAIL branch_word: got %h expected %h", {pc_out, instruction_out}, e);
          end
        end
      end
      tests++;
      if (sb_q.size() != 0) begin
        fails++;
        $display("FAIL branch_timeout: got %0d words left expected 0", sb_q.size());
      end
    end
  endtask

  task automatic test_branch_freeze();
    bit found = 1'b0;
    logic [63:0] e;
    do_reset(0);
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      freeze = 1'b1;
      if (imem_req && imem_ack && (if_valid || !SKID)) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL bfreeze_setup: got no ack cycle expected one within 20 cycles");
    end else begin
      branch_taken = 1'b1;
      branch_addr = 32'h200;
      @(negedge clk);
      branch_taken = 1'b0;
      tests++;
      if (if_valid !== 1'b0) begin
        fails++;
        $display("FAIL bfreeze_flush: got if_valid=%b expected 0", if_valid);
      end
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
        fails++;
        $display("FAIL bfreeze_issue: got req=%b addr=%h expected req=1 addr=00000200",
                 imem_req, imem_addr);
      end
      for (int i = 0; i < 2; i++) sb_q.push_back(exp_pair(32'h200 + 32'(4 * i)));
      for (int c = 0; c < 100 && sb_q.size() > 0; c++) begin
        if (c > 0) @(negedge clk);
        freeze = 1'b1;
        if (if_valid) begin
          e = sb_q.pop_front();
          freeze = 1'b0;
          tests++;
          if ({pc_out, instruction_out} !== e) begin
            fails++;
            $display("FAIL bfreeze_word: got %h expected %h", {pc_out, instruction_out}, e);
          end
        end
      end
      tests++;
      if (sb_q.size() != 0) begin
        fails++;
        $display("FAIL bfreeze_timeout: got %0d words left expected 0", sb_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    logic [63:0] e;
    do_reset(3);
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      freeze = 1'b1;
      if (if_valid) freeze = 1'b0;
      if (imem_req && !imem_ack && imem_addr == 32'h4) found = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (!found || {imem_req, imem_addr, if_valid, pc_out, instruction_out} !== '0) begin
      fails++;
      $display("FAIL reset_mid_async: got found=%b req=%b addr=%h v=%b expected found=1 all 0",
               found, imem_req, imem_addr, if_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    freeze = 1'b1;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
    for (int i = 0; i < 2; i++) sb_q.push_back(exp_pair(32'(4 * i)));
    for (int c = 0; c < 100 && sb_q.size() > 0; c++) begin
      @(negedge clk);
      freeze = 1'b1;
      if (if_valid) begin
        e = sb_q.pop_front();
        freeze = 1'b0;
        tests++;
        if ({pc_out, instruction_out} !== e) begin
          fails++;
          $display("FAIL reset_mid_word: got %h expected %h", {pc_out, instruction_out}, e);
        end
      end
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_timeout: got %0d words left expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_ack_delay();
    test_freeze();
    test_branch_open();
    test_branch_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
